comp_mult_pipe: RTL and testbench
=================================

// Module: comp_mult_pipe
// PURPOSE
//  Fully pipelined signed complex multiplier, one product per cycle at full rate: (x1+jy1)*(x2+jy2).
//  Optional per-transaction conjugate mode and a user tag that travels with each result.
//  Drop-in successor for the sequential complex multiplier in the DSP datapath; same val-rdy IF and {x1,y1,x2,y2} packing.
// PARAMETERS
//  DWIDTH  8   signed operand width per component
//  TWIDTH  4   user tag width (>=1), passed through unchanged
//  OWIDTH  16  saturation width per result component (used only with COMP_MULT_SAT_EN; 2 <= OWIDTH <= 2*DWIDTH+1)
// PORTS
//  clk       in   1                 system clock, rising edge
//  rst_n     in   1                 synchronous reset, active low
//  sw_rst    in   1                 sw synchronous clear, active high
//  op_val    in   1                 input operands valid
//  op_rdy    out  1                 input operands ready
//  op_data   in   4*DWIDTH          {x1,y1,x2,y2}, two's complement
//  op_conj   in   1                 1: multiply by conj(x2+jy2)
//  op_tag    in   TWIDTH            user tag
//  res_val   out  1                 result valid
//  res_rdy   in   1                 result ready
//  res_data  out  2*(2*DWIDTH+2)    {xr,yr}, each sign-extended to 2*DWIDTH+2
//  res_tag   out  TWIDTH            tag of the transaction on res_data
//  res_sat   out  1                 (only with COMP_MULT_SAT_EN) xr or yr was clipped
// BEHAVIOUR
//  Reset: rst_n low or sw_rst high at a rising edge clears all stage valids and data regs; res_val=0, res_data=0,
//   res_tag=0, res_sat=0; op_rdy=1 from the first cycle after reset. rst_n takes priority over sw_rst.
//   Reset mid-operation discards all in-flight transactions; nothing is emitted for them.
//  Pipeline: S1 operand/conj/tag regs -> S2 four product regs (2*DWIDTH each, exact) -> S3 result regs = output.
//  Accept: transfer when op_val & op_rdy at a rising edge N; res_val=1 after edge N+2 (latency 3 stages), with no stall.
//  Flow: v1,v2,v3 stage valids. adv3 = ~v3 | res_rdy; adv2 = ~v2 | adv3; op_rdy = ~v1 | adv2 (combinational).
//   Stages advance independently; bubbles collapse. Max 3 transactions in flight; with res_rdy=0, op_rdy drops after 3 accepts.
//   res_data/res_tag hold stable while res_val & ~res_rdy. Output order = input order.
//   Simultaneous output drain and input accept in one cycle allowed (full throughput at res_rdy=1).
//  Arithmetic (S3, widths 2*DWIDTH+1, exact, no overflow possible):
//   conj=0: xr = x1*x2 - y1*y2 ; yr = x1*y2 + y1*x2
//   conj=1: xr = x1*x2 + y1*y2 ; yr = y1*x2 - x1*y2
//   Products sign-extended before add/sub; result sign-extended by 1 bit to 2*DWIDTH+2 on res_data.
//  op_data/op_conj/op_tag ignored when op_val=0 or op_rdy=0; S1 regs change only on accept.
// CONFIGURATION
//  COMP_MULT_SAT_EN defined: each of xr,yr clipped to signed OWIDTH range [-2^(OWIDTH-1), 2^(OWIDTH-1)-1],
//   then sign-extended to 2*DWIDTH+2; port res_sat present, =1 if either component was clipped, aligned with res_data.
//   Clipping is done in S3; latency unchanged.
//  COMP_MULT_SAT_EN undefined: exact results, no res_sat port, OWIDTH unused.
// TESTING (DWIDTH=8, TWIDTH=4, OWIDTH=16)
//  1 Basic: {3,4,5,-2}, conj=0, tag=5, res_rdy=1 -> after 3 cycles xr=23, yr=14, res_tag=5.
//  2 Conj/corner: {-128,-128,-128,-128} conj=0 -> xr=0, yr=32768; conj=1 -> xr=32768, yr=0; no wrap at 18 bits.
//  3 Throughput: 16 back-to-back random txns, res_rdy=1 -> op_rdy stays 1, results 1/cycle, in order, tags match model.
//  4 Backpressure: res_rdy=0, op_val=1 -> exactly 3 accepts, op_rdy=0; res_data stable; release res_rdy -> 3 results in order, no loss/dup.
//  5 Reset: rst_n=0 for 1 cycle with 2 txns in flight -> next cycle res_val=0, op_rdy=1, no stale result ever emitted; repeat with sw_rst.
//  6 SAT_EN: case 2, conj=1 -> xr=32767, res_sat=1; case 1 -> res_sat=0, exact values.

Source files
------------

// File: rtl/comp_mult_if.sv
// -----------------------------------------------------------------------------
// comp_mult_if
// Valid/ready bundle for the pipelined complex multiplier.
//   op_val/op_rdy   : operand handshake
//   op_data         : {x1,y1,x2,y2}, DWIDTH bits each, two's complement
//   op_conj         : 1 = multiply by conj(x2+jy2)
//   op_tag          : user tag, returned unchanged on res_tag
//   res_val/res_rdy : result handshake
//   res_data        : {xr,yr}, each 2*DWIDTH+2 bits, sign extended
//   res_tag         : tag of the transaction on res_data
//   res_sat         : only with COMP_MULT_SAT_EN; xr or yr was clipped
// Modports: master = operand source / result sink, slave = multiplier.
// -----------------------------------------------------------------------------
interface comp_mult_if #(
    parameter int DWIDTH = 8,
    parameter int TWIDTH = 4
);
    logic                        op_val;
    logic                        op_rdy;
    logic [4*DWIDTH-1:0]         op_data;
    logic                        op_conj;
    logic [TWIDTH-1:0]           op_tag;
    logic                        res_val;
    logic                        res_rdy;
    logic [2*(2*DWIDTH+2)-1:0]   res_data;
    logic [TWIDTH-1:0]           res_tag;
`ifdef COMP_MULT_SAT_EN
    logic                        res_sat;

    modport master (
        output op_val, op_data, op_conj, op_tag, res_rdy,
        input  op_rdy, res_val, res_data, res_tag, res_sat
    );
    modport slave (
        input  op_val, op_data, op_conj, op_tag, res_rdy,
        output op_rdy, res_val, res_data, res_tag, res_sat
    );
`else
    modport master (
        output op_val, op_data, op_conj, op_tag, res_rdy,
        input  op_rdy, res_val, res_data, res_tag
    );
    modport slave (
        input  op_val, op_data, op_conj, op_tag, res_rdy,
        output op_rdy, res_val, res_data, res_tag
    );
`endif
endinterface

// File: rtl/comp_mult_pipe.sv
// -----------------------------------------------------------------------------
// comp_mult_pipe
// Fully pipelined signed complex multiplier (x1+jy1)*(x2+jy2), one result per
// cycle, latency 3 stages, optional conjugate of the second operand per
// transaction and a user tag carried alongside each result.
//   S1: operand / conj / tag registers
//   S2: four exact 2*DWIDTH-bit partial products
//   S3: add/sub (2*DWIDTH+1 bits, exact) -> output registers
// Ports:
//   clk     : rising-edge clock
//   rst_n   : synchronous reset, active low (wins over sw_rst)
//   sw_rst  : synchronous software clear, active high
//   bus     : comp_mult_if.slave (operand and result handshakes)
// Configuration macro COMP_MULT_SAT_EN: clip xr/yr to signed OWIDTH in S3 and
// drive bus.res_sat; otherwise results are exact and OWIDTH is only range
// checked.
// -----------------------------------------------------------------------------
module comp_mult_pipe #(
    parameter int DWIDTH = 8,
    parameter int TWIDTH = 4,
    parameter int OWIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sw_rst,
    comp_mult_if.slave  bus
);
    localparam int PW = 2 * DWIDTH;   // exact product width
    localparam int RW = PW + 1;       // exact sum width

    if (OWIDTH < 2 || OWIDTH > RW) begin : g_owidth_check
        $error("comp_mult_pipe: OWIDTH out of range");
    end

    // Stage valids and handshake chain
    logic v1_reg, v2_reg, v3_reg;
    logic adv2, adv3, op_rdy_int;

    assign adv3       = ~v3_reg | bus.res_rdy;
    assign adv2       = ~v2_reg | adv3;
    assign op_rdy_int = ~v1_reg | adv2;

    // Operand unpack: index 0..3 = x1, y1, x2, y2
    logic signed [DWIDTH-1:0] op_comp [4];
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_unpack
        assign op_comp[gi] = bus.op_data[(3-gi)*DWIDTH +: DWIDTH];
    end

    // ---------------- S1 ----------------
    logic signed [DWIDTH-1:0] opnd_reg [4];
    logic                     conj1_reg;
    logic [TWIDTH-1:0]        tag1_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || sw_rst) begin
            v1_reg    <= 1'b0;
            conj1_reg <= 1'b0;
            tag1_reg  <= '0;
            for (int i = 0; i < 4; i++) opnd_reg[i] <= '0;
        end else if (op_rdy_int) begin
            v1_reg <= bus.op_val;
            if (bus.op_val) begin
                conj1_reg <= bus.op_conj;
                tag1_reg  <= bus.op_tag;
                for (int i = 0; i < 4; i++) opnd_reg[i] <= op_comp[i];
            end
        end
    end

    // ---------------- S2 ----------------
    logic signed [PW-1:0] p_xx, p_yy, p_xy, p_yx;
    logic signed [PW-1:0] pxx_reg, pyy_reg, pxy_reg, pyx_reg;
    logic                 conj2_reg;
    logic [TWIDTH-1:0]    tag2_reg;

    // Operands widened first so the multiply is evaluated at full width.
    assign p_xx = PW'(opnd_reg[0]) * PW'(opnd_reg[2]);
    assign p_yy = PW'(opnd_reg[1]) * PW'(opnd_reg[3]);
    assign p_xy = PW'(opnd_reg[0]) * PW'(opnd_reg[3]);
    assign p_yx = PW'(opnd_reg[1]) * PW'(opnd_reg[2]);

    always_ff @(posedge clk) begin
        if (!rst_n || sw_rst) begin
            v2_reg    <= 1'b0;
            conj2_reg <= 1'b0;
            tag2_reg  <= '0;
            pxx_reg   <= '0;
            pyy_reg   <= '0;
            pxy_reg   <= '0;
            pyx_reg   <= '0;
        end else if (adv2) begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
                conj2_reg <= conj1_reg;
                tag2_reg  <= tag1_reg;
                pxx_reg   <= p_xx;
                pyy_reg   <= p_yy;
                pxy_reg   <= p_xy;
                pyx_reg   <= p_yx;
            end
        end
    end

    // ---------------- S3 ----------------
    // sum_c[0] = real part, sum_c[1] = imaginary part
    logic signed [RW-1:0] sum_c [2];
    logic signed [RW-1:0] res_c [2];
    logic [1:0]           clip_c;

    always_comb begin
        sum_c[0] = '0;
        sum_c[1] = '0;
        if (conj2_reg) begin
            sum_c[0] = RW'(pxx_reg) + RW'(pyy_reg);
            sum_c[1] = RW'(pyx_reg) - RW'(pxy_reg);
        end else begin
            sum_c[0] = RW'(pxx_reg) - RW'(pyy_reg);
            sum_c[1] = RW'(pxy_reg) + RW'(pyx_reg);
        end
    end

`ifdef COMP_MULT_SAT_EN
    localparam logic signed [RW-1:0] SAT_MAX = {{(RW-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = {{(RW-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};

    for (gi = 0; gi < 2; gi++) begin : g_sat
        assign clip_c[gi] = (sum_c[gi] > SAT_MAX) || (sum_c[gi] < SAT_MIN);
        assign res_c[gi]  = (sum_c[gi] > SAT_MAX) ? SAT_MAX :
                            (sum_c[gi] < SAT_MIN) ? SAT_MIN : sum_c[gi];
    end
`else
    for (gi = 0; gi < 2; gi++) begin : g_exact
        assign clip_c[gi] = 1'b0;
        assign res_c[gi]  = sum_c[gi];
    end
`endif

    logic signed [RW-1:0] xr_reg, yr_reg;
    logic [TWIDTH-1:0]    tag3_reg;
    logic                 sat3_reg;

    // Output holds while v3 & ~res_rdy because adv3 is low then.
    always_ff @(posedge clk) begin
        if (!rst_n || sw_rst) begin
            v3_reg   <= 1'b0;
            xr_reg   <= '0;
            yr_reg   <= '0;
            tag3_reg <= '0;
            sat3_reg <= 1'b0;
        end else if (adv3) begin
            v3_reg <= v2_reg;
            if (v2_reg) begin
                xr_reg   <= res_c[0];
                yr_reg   <= res_c[1];
                tag3_reg <= tag2_reg;
                sat3_reg <= |clip_c;
            end
        end
    end

    assign bus.op_rdy   = op_rdy_int;
    assign bus.res_val  = v3_reg;
    assign bus.res_data = {xr_reg[RW-1], xr_reg, yr_reg[RW-1], yr_reg};
    assign bus.res_tag  = tag3_reg;
`ifdef COMP_MULT_SAT_EN
    assign bus.res_sat  = sat3_reg;
`else
    logic unused_sat;
    assign unused_sat = sat3_reg;
`endif

endmodule

// File: tb/tb_comp_mult_pipe.sv
// -----------------------------------------------------------------------------
// tb_comp_mult_pipe
// Self-checking bench for comp_mult_pipe (DWIDTH=8, TWIDTH=4, OWIDTH=16).
// A negedge monitor pushes an expected result (computed with plain integer
// complex arithmetic) for every accepted operand and pops/compares it for
// every result handshake. Directed table vectors, throughput, backpressure
// and reset sequences run on top of that.
// -----------------------------------------------------------------------------
module tb_comp_mult_pipe;
    localparam int DW = 8;
    localparam int TW = 4;
    localparam int OW = 16;
    localparam int CW = 2*DW + 2;
    localparam int SAT_HI = (1 << (OW-1)) - 1;
    localparam int SAT_LO = -(1 << (OW-1));

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sw_rst = 1'b0;
    always #5 clk = ~clk;

    comp_mult_if #(.DWIDTH(DW), .TWIDTH(TW)) bus ();

    comp_mult_pipe #(.DWIDTH(DW), .TWIDTH(TW), .OWIDTH(OW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw_rst (sw_rst),
        .bus    (bus)
    );

    typedef struct {
        int          xr;
        int          yr;
        logic [TW-1:0] tag;
        bit          sat;
    } exp_t;

    typedef struct {
        int          x1, y1, x2, y2;
        bit          conj;
        logic [TW-1:0] tag;
        int          xr, yr;
    } vec_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int res_count = 0;
    bit tp_phase = 0;
    int tp_n = 0, tp_first = 0, tp_last = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat_val(int v);
        if (v > SAT_HI) return SAT_HI;
        if (v < SAT_LO) return SAT_LO;
        return v;
    endfunction

    // Reference: complex product from the definition, then optional clipping
    function automatic exp_t model(int x1, int y1, int x2, int y2, bit conj, logic [TW-1:0] tag);
        exp_t m;
        m.xr  = conj ? (x1*x2 + y1*y2) : (x1*x2 - y1*y2);
        m.yr  = conj ? (y1*x2 - x1*y2) : (x1*y2 + y1*x2);
        m.tag = tag;
        m.sat = 1'b0;
`ifdef COMP_MULT_SAT_EN
        m.sat = (sat_val(m.xr) != m.xr) || (sat_val(m.yr) != m.yr);
        m.xr  = sat_val(m.xr);
        m.yr  = sat_val(m.yr);
`endif
        return m;
    endfunction

    function automatic int comp(logic [4*DW-1:0] d, int idx);
        logic signed [DW-1:0] c;
        c = d[(3-idx)*DW +: DW];
        return int'(c);
    endfunction

    function automatic int act_xr();
        logic signed [CW-1:0] v;
        v = bus.res_data[2*CW-1 -: CW];
        return int'(v);
    endfunction

    function automatic int act_yr();
        logic signed [CW-1:0] v;
        v = bus.res_data[CW-1:0];
        return int'(v);
    endfunction

    // Scoreboard monitor; handshakes seen here complete at the next rising edge
    always @(negedge clk) begin
        if (!rst_n || sw_rst) begin
            exp_q.delete();
        end else begin
            if (bus.res_val && bus.res_rdy) begin
                res_count++;
                if (tp_phase) begin
                    if (tp_n == 0) tp_first = cyc;
                    tp_last = cyc;
                    tp_n++;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got tag %0d, required none", bus.res_tag);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("txn tag=%0d xr=%0d yr=%0d (exp %0d %0d)", bus.res_tag, act_xr(), act_yr(), e.xr, e.yr);
                    check("sb_xr", act_xr(), e.xr);
                    check("sb_yr", act_yr(), e.yr);
                    check("sb_tag", int'(bus.res_tag), int'(e.tag));
`ifdef COMP_MULT_SAT_EN
                    check("sb_sat", int'(bus.res_sat), int'(e.sat));
`endif
                end
            end
            if (bus.op_val && bus.op_rdy)
                exp_q.push_back(model(comp(bus.op_data, 0), comp(bus.op_data, 1),
                                      comp(bus.op_data, 2), comp(bus.op_data, 3),
                                      bus.op_conj, bus.op_tag));
        end
    end

    task automatic drive(int x1, int y1, int x2, int y2, bit conj, logic [TW-1:0] tag);
        bus.op_val  = 1'b1;
        bus.op_data = {DW'(x1), DW'(y1), DW'(x2), DW'(y2)};
        bus.op_conj = conj;
        bus.op_tag  = tag;
    endtask

    task automatic drive_rand();
        drive(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
              int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
              1'($urandom_range(0, 1)), TW'($urandom_range(0, 15)));
    endtask

    task automatic wait_drain(string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    // Two in-flight transactions, then a one-cycle reset via rst_n or sw_rst
    task automatic reset_midflight(bit use_sw);
        int stale;
        @(posedge clk); #1;
        drive_rand();
        @(posedge clk); #1;
        drive_rand();
        @(posedge clk); #1;
        bus.op_val = 1'b0;
        if (use_sw) sw_rst = 1'b1; else rst_n = 1'b0;
        @(posedge clk); #1;
        sw_rst = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        check(use_sw ? "swrst_res_val" : "rst_res_val", int'(bus.res_val), 0);
        check(use_sw ? "swrst_op_rdy" : "rst_op_rdy", int'(bus.op_rdy), 1);
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.res_val) stale++;
        end
        check(use_sw ? "swrst_no_stale" : "rst_no_stale", stale, 0);
    endtask

    vec_t tbl[10];

    initial begin
        int lat, rc0, acc;
        logic [2*CW-1:0] held_data;
        logic [TW-1:0]   held_tag;

        tbl[0] = '{3, 4, 5, -2, 1'b0, 4'd5, 23, 14};
        tbl[1] = '{-128, -128, -128, -128, 1'b0, 4'd1, 0, 32768};
        tbl[2] = '{-128, -128, -128, -128, 1'b1, 4'd2, 32768, 0};
        tbl[3] = '{127, -128, 127, -128, 1'b0, 4'd3, -255, -32512};
        tbl[4] = '{127, -128, 127, -128, 1'b1, 4'd4, 32513, 0};
        tbl[5] = '{-1, 0, 0, -1, 1'b0, 4'd6, 0, 1};
        tbl[6] = '{-1, 0, 0, -1, 1'b1, 4'd7, 0, -1};
        tbl[7] = '{0, 0, 0, 0, 1'b0, 4'd15, 0, 0};
        tbl[8] = '{127, 127, 127, 127, 1'b1, 4'd9, 32258, 0};
        tbl[9] = '{-128, 127, 127, -128, 1'b0, 4'd10, 0, 32513};

        bus.op_val  = 1'b0;
        bus.op_data = '0;
        bus.op_conj = 1'b0;
        bus.op_tag  = '0;
        bus.res_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("reset_res_val", int'(bus.res_val), 0);
        check("reset_res_data", int'(bus.res_data), 0);
        check("reset_res_tag", int'(bus.res_tag), 0);
        check("reset_op_rdy", int'(bus.op_rdy), 1);
`ifdef COMP_MULT_SAT_EN
        check("reset_res_sat", int'(bus.res_sat), 0);
`endif

        // Directed vectors, one at a time, with latency check
        for (int i = 0; i < 10; i++) begin
            int ex, ey;
            bit es;
            @(posedge clk); #1;
            drive(tbl[i].x1, tbl[i].y1, tbl[i].x2, tbl[i].y2, tbl[i].conj, tbl[i].tag);
            @(posedge clk); #1;
            bus.op_val = 1'b0;
            lat = 0;
            @(negedge clk);
            while (!bus.res_val && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            ex = tbl[i].xr;
            ey = tbl[i].yr;
            es = 1'b0;
`ifdef COMP_MULT_SAT_EN
            es = (sat_val(ex) != ex) || (sat_val(ey) != ey);
            ex = sat_val(ex);
            ey = sat_val(ey);
            check("tbl_sat", int'(bus.res_sat), int'(es));
`endif
            check("tbl_latency", lat, 2);
            check("tbl_xr", act_xr(), ex);
            check("tbl_yr", act_yr(), ey);
            check("tbl_tag", int'(bus.res_tag), int'(tbl[i].tag));
        end
        wait_drain("tbl_drain");

        // Throughput: 16 back-to-back, res_rdy=1
        tp_phase = 1'b1;
        tp_n = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            drive_rand();
            @(negedge clk);
            check("tp_op_rdy", int'(bus.op_rdy), 1);
            @(posedge clk); #1;
        end
        bus.op_val = 1'b0;
        wait_drain("tp_drain");
        tp_phase = 1'b0;
        check("tp_count", tp_n, 16);
        check("tp_rate", tp_last - tp_first, 15);

        // Backpressure: exactly three accepts, held output, ordered drain
        rc0 = res_count;
        acc = 0;
        held_data = '0;
        held_tag  = '0;
        @(posedge clk); #1;
        bus.res_rdy = 1'b0;
        drive_rand();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.op_val && bus.op_rdy) acc++;
            if (i == 3) begin
                held_data = bus.res_data;
                held_tag  = bus.res_tag;
            end
            if (i > 3) begin
                check("bp_data_hold", int'(bus.res_data == held_data), 1);
                check("bp_tag_hold", int'(bus.res_tag), int'(held_tag));
            end
            @(posedge clk); #1;
            drive_rand();
        end
        @(negedge clk);
        check("bp_accepts", acc, 3);
        check("bp_op_rdy", int'(bus.op_rdy), 0);
        check("bp_res_val", int'(bus.res_val), 1);
        @(posedge clk); #1;
        bus.op_val  = 1'b0;
        bus.res_rdy = 1'b1;
        wait_drain("bp_drain");
        check("bp_results", res_count - rc0, 3);

        // Reset with transactions in flight
        reset_midflight(1'b0);
        reset_midflight(1'b1);

        // Random traffic with random backpressure after the resets
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            bus.res_rdy = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) drive_rand(); else bus.op_val = 1'b0;
        end
        @(posedge clk); #1;
        bus.op_val  = 1'b0;
        bus.res_rdy = 1'b1;
        wait_drain("rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end, required completion");
        $fatal(1, "timeout");
    end

endmodule
